// File: rtl/taylor_trig_horner.sv
`default_nettype none
// ============================================================================
// Module      : taylor_trig_horner
// Description : Fixed-point Taylor-series cos/sin evaluator using a Horner
//               scheme over TERMS terms with a single shared multiplier.
//               start/busy/done handshake; result saturated to [-ONE, +ONE].
// Revision    : 1.0 - initial release
// ============================================================================
module taylor_trig_horner #(
    parameter int W     = 24,
    parameter int FRAC  = 10,
    parameter int TERMS = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic signed [W-1:0] angle,
    output logic                busy,
    output logic                done,
    output logic signed [W-1:0] result
);

    localparam int                    C_KW         = (TERMS > 2) ? $clog2(TERMS) : 1;
    localparam longint                C_ONE_L      = longint'(1) <<< FRAC;
    localparam logic signed [W-1:0]   C_ONE        = C_ONE_L[W-1:0];
    localparam logic signed [W-1:0]   C_NEG_ONE    = -C_ONE;
    localparam logic signed [2*W-1:0] C_ONE_2W     = {{W{1'b0}}, C_ONE};
    localparam logic signed [2*W-1:0] C_NEG_ONE_2W = -C_ONE_2W;

    // Reject unsupported term counts at elaboration time.
    if (TERMS < 2 || TERMS > 8) begin : g_bad_terms
        $error("taylor_trig_horner: TERMS must lie in 2..8");
    end

    // Rounded reciprocal of the Horner denominator for term k.
    function automatic logic signed [W-1:0] coef(input bit is_sin, input int k);
        longint d;
        longint v;
        d = is_sin ? longint'((2 * k) * (2 * k + 1)) : longint'((2 * k - 1) * (2 * k));
        v = (C_ONE_L + d / 2) / d;
        return v[W-1:0];
    endfunction

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SQUARE = 3'd1,
        S_ITER_A = 3'd2,
        S_ITER_B = 3'd3,
        S_FINAL  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic signed [W-1:0]   r_x;
    logic                  r_m;
    logic signed [W-1:0]   r_x2;
    logic signed [W-1:0]   r_acc;
    logic signed [W-1:0]   r_t;
    logic [C_KW-1:0]       r_k;
    logic                  r_busy;
    logic                  r_done;
    logic signed [W-1:0]   r_result;

    logic signed [W-1:0]   w_cos_c [1:TERMS-1];
    logic signed [W-1:0]   w_sin_c [1:TERMS-1];
    logic signed [W-1:0]   w_coef;
    logic signed [W-1:0]   w_op_a;
    logic signed [W-1:0]   w_op_b;
    logic signed [2*W-1:0] w_prod;
    logic signed [2*W-1:0] w_shift;
    logic signed [W-1:0]   w_shift_w;
    logic signed [2*W-1:0] w_sat_src;
    logic signed [W-1:0]   w_sat;

    // Coefficient tables, one entry per Horner step, fixed at elaboration.
    for (genvar gk = 1; gk < TERMS; gk++) begin : g_coef
        assign w_cos_c[gk] = coef(1'b0, gk);
        assign w_sin_c[gk] = coef(1'b1, gk);
    end

    assign w_coef = r_m ? w_sin_c[r_k] : w_cos_c[r_k];

    // Route the shared multiplier operands according to the current step.
    always_comb begin
        w_op_a = r_x;
        w_op_b = r_x;
        case (r_state)
            S_ITER_A: begin w_op_a = r_x2; w_op_b = r_acc;  end
            S_ITER_B: begin w_op_a = r_t;  w_op_b = w_coef; end
            S_FINAL:  begin w_op_a = r_x;  w_op_b = r_acc;  end
            default:  ;
        endcase
    end

    assign w_prod    = {{W{w_op_a[W-1]}}, w_op_a} * {{W{w_op_b[W-1]}}, w_op_b};
    assign w_shift   = w_prod >>> FRAC;
    assign w_shift_w = w_shift[W-1:0];

    // Clamp the final value; sine uses the full-width product so overflow saturates.
    always_comb begin
        w_sat_src = r_m ? w_shift : {{W{r_acc[W-1]}}, r_acc};
        if (w_sat_src > C_ONE_2W)
            w_sat = C_ONE;
        else if (w_sat_src < C_NEG_ONE_2W)
            w_sat = C_NEG_ONE;
        else
            w_sat = w_sat_src[W-1:0];
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state sequencing: square, then TERMS-1 alternating A/B steps, then final.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_SQUARE;
            S_SQUARE: w_next = S_ITER_A;
            S_ITER_A: w_next = S_ITER_B;
            S_ITER_B: w_next = (r_k == C_KW'(1)) ? S_FINAL : S_ITER_A;
            S_FINAL:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Datapath registers and handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_x      <= '0;
            r_m      <= 1'b0;
            r_x2     <= '0;
            r_acc    <= '0;
            r_t      <= '0;
            r_k      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x    <= angle;
                        r_m    <= mode;
                        r_busy <= 1'b1;
                    end
                end
                S_SQUARE: begin
                    r_x2  <= w_shift_w;
                    r_acc <= C_ONE;
                    r_k   <= C_KW'(TERMS - 1);
                end
                S_ITER_A: r_t <= w_shift_w;
                S_ITER_B: begin
                    r_acc <= C_ONE - w_shift_w;
                    if (r_k != C_KW'(1)) r_k <= r_k - C_KW'(1);
                end
                S_FINAL: begin
                    r_result <= w_sat;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule
`default_nettype wire
